// File: rtl/adder_final.sv
`default_nettype none
// ============================================================================
//  Module      : adder_final
//  Description : Final carry-propagate stage of a carry-save accumulator.
//                It collapses the two carry-save rows, covering columns 19..5,
//                into a 20-bit two's-complement sum S. S is built with a
//                Kogge-Stone prefix adder and registered with one cycle of
//                latency. The outputs are the raw sum bits 19..6 and a
//                13-bit result that is optionally saturated.
//
//  Ports       : clk        - rising-edge clock
//                reset      - synchronous active-high reset
//                in_valid   - qualifies the column inputs this cycle
//                a19..a6    - two carry-save bits per column (weight 2^k)
//                a5         - single bit of column 5
//                out        - registered S[19:6]
//                sat_out    - registered result over accumulator bits 18..6
//                ovf_pos    - registered positive-overflow flag
//                ovf_neg    - registered negative-overflow flag
//                out_valid  - high one cycle after an accepted in_valid
//
//  Config      : ADDER_FINAL_SAT_EN - when defined, sat_out saturates to
//                +4095/-4096 and the overflow flags are live. When it is
//                undefined, sat_out wraps (out[12:0]) and the flags are 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_final (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [1:0]  a19,
    input  logic [1:0]  a18,
    input  logic [1:0]  a17,
    input  logic [1:0]  a16,
    input  logic [1:0]  a15,
    input  logic [1:0]  a14,
    input  logic [1:0]  a13,
    input  logic [1:0]  a12,
    input  logic [1:0]  a11,
    input  logic [1:0]  a10,
    input  logic [1:0]  a9,
    input  logic [1:0]  a8,
    input  logic [1:0]  a7,
    input  logic [1:0]  a6,
    input  logic        a5,
    output logic [13:0] out,
    output logic [12:0] sat_out,
    output logic        ovf_pos,
    output logic        ovf_neg,
    output logic        out_valid
);

    localparam int c_WIDTH  = 15;   // columns 19..5, position 0 = column 5
    localparam int c_LEVELS = 4;    // ceil(log2(15)) prefix levels

    logic [c_WIDTH-1:0] w_x;
    logic [c_WIDTH-1:0] w_y;

    assign w_x = {a19[0], a18[0], a17[0], a16[0], a15[0], a14[0], a13[0],
                  a12[0], a11[0], a10[0], a9[0],  a8[0],  a7[0],  a6[0], a5};
    assign w_y = {a19[1], a18[1], a17[1], a16[1], a15[1], a14[1], a13[1],
                  a12[1], a11[1], a10[1], a9[1],  a8[1],  a7[1],  a6[1], 1'b0};

    // Generate/propagate per prefix level. Level 0 holds the bitwise terms.
    logic [c_WIDTH-1:0] w_g [0:c_LEVELS];
    logic [c_WIDTH-1:0] w_p [0:c_LEVELS];

    assign w_g[0] = w_x & w_y;
    assign w_p[0] = w_x ^ w_y;

    generate
        for (genvar lvl = 0; lvl < c_LEVELS; lvl++) begin : g_level
            for (genvar i = 0; i < c_WIDTH; i++) begin : g_bit
                if (i >= (1 << lvl)) begin : g_merge
                    assign w_g[lvl+1][i] = w_g[lvl][i] |
                                           (w_p[lvl][i] & w_g[lvl][i-(1<<lvl)]);
                    assign w_p[lvl+1][i] = w_p[lvl][i] & w_p[lvl][i-(1<<lvl)];
                end else begin : g_pass
                    // The group already reaches position 0, so it is final.
                    assign w_g[lvl+1][i] = w_g[lvl][i];
                    assign w_p[lvl+1][i] = w_p[lvl][i];
                end
            end
        end
    endgenerate

    // The carry-in at column 5 is zero. Column i receives the group
    // generate of columns 0..i-1.
    logic [c_WIDTH-1:0] w_carry;
    logic [c_WIDTH-1:0] w_s;
    logic [13:0]        w_sum;

    assign w_carry = {w_g[c_LEVELS][c_WIDTH-2:0], 1'b0};
    assign w_s     = w_p[0] ^ w_carry;
    assign w_sum   = w_s[c_WIDTH-1:1];   // bit 5 only matters via its carry

    // The carry out of bit 19 is discarded. The final-level propagate and
    // sum bit 5 have no consumer.
    logic w_unused;
    assign w_unused = ^{w_g[c_LEVELS][c_WIDTH-1], w_p[c_LEVELS], w_s[0]};

    logic [12:0] w_sat;
    logic        w_ovf_pos;
    logic        w_ovf_neg;

`ifdef ADDER_FINAL_SAT_EN
    // The value leaves the 13-bit signed range exactly when bits 19 and 18
    // of S disagree.
    assign w_ovf_pos = ~w_sum[13] &  w_sum[12];
    assign w_ovf_neg =  w_sum[13] & ~w_sum[12];
    assign w_sat     = w_ovf_pos ? 13'h0FFF :
                       w_ovf_neg ? 13'h1000 : w_sum[12:0];
`else
    assign w_ovf_pos = 1'b0;
    assign w_ovf_neg = 1'b0;
    assign w_sat     = w_sum[12:0];
`endif

    logic [13:0] r_out;
    logic [12:0] r_sat;
    logic        r_ovf_pos;
    logic        r_ovf_neg;
    logic        r_out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_sat       <= '0;
            r_ovf_pos   <= 1'b0;
            r_ovf_neg   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out     <= w_sum;
                r_sat     <= w_sat;
                r_ovf_pos <= w_ovf_pos;
                r_ovf_neg <= w_ovf_neg;
            end
        end
    end

    assign out       = r_out;
    assign sat_out   = r_sat;
    assign ovf_pos   = r_ovf_pos;
    assign ovf_neg   = r_ovf_neg;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_adder_final.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_final
//  Description : Self-checking bench for adder_final. It applies directed
//                column patterns and then a random stream with a reset in
//                the middle. Every output is compared against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_final;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        a5;
    logic [1:0]  col [6:19];
    logic [13:0] out;
    logic [12:0] sat_out;
    logic        ovf_pos;
    logic        ovf_neg;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    // Expected registered state
    logic [13:0] e_out;
    logic [12:0] e_sat;
    logic        e_pos;
    logic        e_neg;
    logic        e_valid;

    adder_final dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a19       (col[19]),
        .a18       (col[18]),
        .a17       (col[17]),
        .a16       (col[16]),
        .a15       (col[15]),
        .a14       (col[14]),
        .a13       (col[13]),
        .a12       (col[12]),
        .a11       (col[11]),
        .a10       (col[10]),
        .a9        (col[9]),
        .a8        (col[8]),
        .a7        (col[7]),
        .a6        (col[6]),
        .a5        (a5),
        .out       (out),
        .sat_out   (sat_out),
        .ovf_pos   (ovf_pos),
        .ovf_neg   (ovf_neg),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference: S = (X + Y) mod 2^20. The result is read as the signed
    // value of S/64 and clamped to the 13-bit signed range.
    task automatic model(output logic [13:0] o, output logic [12:0] s,
                         output logic p, output logic n);
        longint x;
        longint y;
        longint sum;
        int     v;
        x = a5 ? 32 : 0;
        y = 0;
        for (int k = 6; k <= 19; k++) begin
            x += longint'(col[k][0]) << k;
            y += longint'(col[k][1]) << k;
        end
        sum = (x + y) % (longint'(1) << 20);
        o   = 14'(sum >> 6);
        v   = (o >= 14'd8192) ? int'(o) - 16384 : int'(o);
`ifdef ADDER_FINAL_SAT_EN
        p = (v > 4095);
        n = (v < -4096);
        s = p ? 13'(4095) : n ? 13'h1000 : 13'(v);
`else
        p = 1'b0;
        n = 1'b0;
        s = 13'(v);
`endif
    endtask

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_cols();
        a5 = 1'b0;
        for (int k = 6; k <= 19; k++) col[k] = 2'b00;
    endtask

    // One clock: apply controls, advance the model, sample 1 time unit
    // after the edge, and compare all outputs.
    task automatic cycle(input logic r, input logic v, input string tag);
        logic [13:0] o;
        logic [12:0] s;
        logic        p;
        logic        n;
        reset    = r;
        in_valid = v;
        model(o, s, p, n);
        if (r) begin
            e_out = '0; e_sat = '0; e_pos = 1'b0; e_neg = 1'b0; e_valid = 1'b0;
        end else begin
            e_valid = v;
            if (v) begin
                e_out = o; e_sat = s; e_pos = p; e_neg = n;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".out"},       out,              e_out);
        chk({tag, ".sat_out"},   14'(sat_out),     14'(e_sat));
        chk({tag, ".ovf_pos"},   14'(ovf_pos),     14'(e_pos));
        chk({tag, ".ovf_neg"},   14'(ovf_neg),     14'(e_neg));
        chk({tag, ".out_valid"}, 14'(out_valid),   14'(e_valid));
    endtask

    initial begin
        clear_cols();
        reset    = 1'b1;
        in_valid = 1'b0;

        cycle(1'b1, 1'b0, "reset0");
        cycle(1'b1, 1'b1, "reset1");

        // All zero
        cycle(1'b0, 1'b1, "zero");
        chk("zero.lit", out, 14'd0);

        // S = 160
        col[6] = 2'b11; a5 = 1'b1;
        cycle(1'b0, 1'b1, "s160");
        chk("s160.lit", out, 14'd2);
        chk("s160.sat", 14'(sat_out), 14'd2);

        // S = 96
        col[6] = 2'b01;
        cycle(1'b0, 1'b1, "s96");
        chk("s96.lit", out, 14'd1);

        // S = 2^18, positive overflow
        clear_cols(); col[18] = 2'b01;
        cycle(1'b0, 1'b1, "pos");
        chk("pos.lit", out, 14'h1000);
`ifdef ADDER_FINAL_SAT_EN
        chk("pos.sat", 14'(sat_out), 14'h0FFF);
        chk("pos.flag", 14'(ovf_pos), 14'd1);
`else
        chk("pos.sat", 14'(sat_out), 14'h1000);
        chk("pos.flag", 14'(ovf_pos), 14'd0);
`endif

        // S = -2^19, negative overflow
        clear_cols(); col[19] = 2'b01;
        cycle(1'b0, 1'b1, "neg");
        chk("neg.lit", out, 14'h2000);

        // S = -64
        for (int k = 6; k <= 19; k++) col[k] = 2'b01;
        cycle(1'b0, 1'b1, "m64");
        chk("m64.lit", out, 14'h3FFF);
        chk("m64.sat", 14'(sat_out), 14'h1FFF);

        // Hold: new inputs with in_valid low must not disturb the outputs
        for (int k = 6; k <= 19; k++) col[k] = 2'b10;
        cycle(1'b0, 1'b0, "hold");
        chk("hold.lit", out, 14'h3FFF);

        // Reset overrides a simultaneous in_valid
        cycle(1'b1, 1'b1, "rstdrop");

        // Random stream with a mid-stream reset
        for (int c = 0; c < 400; c++) begin
            a5 = 1'($urandom);
            for (int k = 6; k <= 19; k++) col[k] = 2'($urandom);
            if (c == 200 || c == 201)
                cycle(1'b1, 1'($urandom), "rnd_rst");
            else
                cycle(1'b0, ($urandom_range(0, 3) != 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
